aes_inv_shift_rows_stream: RTL and testbench

Byte-serial to block converter for the AES decryption path. Accepts a 16-byte AES state one byte per beat over a valid/ready stream, in column-major order with byte 0 first. Applies InvShiftRows and presents the 128-bit result on a valid/ready block interface. Ping-pong buffering sustains 1 byte/cycle input while the downstream block consumer stalls.

---
 rtl/aes_inv_shift_rows_stream_if.sv | 32 +++
 rtl/aes_inv_shift_rows_stream.sv | 129 ++++++++++++
 tb/tb_aes_inv_shift_rows_stream.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_shift_rows_stream_if.sv
// Stream bundle for aes_inv_shift_rows_stream: byte-wide input stream and 128-bit block output.
// AES_SR_BIDIR_EN adds the per-block mode select carried alongside the input bytes.
interface aes_inv_shift_rows_stream_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
`ifdef AES_SR_BIDIR_EN
  logic         mode;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_last,
`ifdef AES_SR_BIDIR_EN
    output mode,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
`ifdef AES_SR_BIDIR_EN
    input  mode,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_shift_rows_stream.sv
// Byte-serial to 128-bit block converter applying InvShiftRows, ping-pong buffered.
// Optional macro AES_SR_BIDIR_EN adds a per-block mode input selecting forward/inverse ShiftRows.
module aes_inv_shift_rows_stream #(
  parameter int LAST_CHECK = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  aes_inv_shift_rows_stream_if.slave  bus,
  output logic                        err
);

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
      end
    end
    return o;
  endfunction

`ifdef AES_SR_BIDIR_EN
  function automatic logic [127:0] fwd_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
      end
    end
    return o;
  endfunction
`endif

  logic [127:0] buf_q [2];
  logic [1:0]   full_q, full_d;
  logic         wr_sel_q, wr_sel_d;
  logic         rd_sel_q, rd_sel_d;
  logic [3:0]   wr_cnt_q, wr_cnt_d;
  logic         err_q, err_d;
`ifdef AES_SR_BIDIR_EN
  logic [1:0]   mode_q;
`endif

  logic in_ready_w;
  logic out_valid_w;
  logic accept;
  logic drain;
  logic last_beat;
  logic frame_err;
  logic complete;

  // in_ready depends only on registered flags, never on out_ready
  assign in_ready_w  = ~full_q[wr_sel_q];
  assign out_valid_w = full_q[rd_sel_q];
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign err           = err_q;

  always_comb begin
    accept    = bus.in_valid & in_ready_w;
    drain     = out_valid_w & bus.out_ready;
    last_beat = (wr_cnt_q == 4'd15);
    frame_err = 1'b0;
    if (LAST_CHECK != 0) begin
      frame_err = accept && (bus.in_last != last_beat);
    end
    complete  = accept && last_beat && !frame_err;

    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = frame_err;

    if (accept) begin
      wr_cnt_d = (frame_err || last_beat) ? 4'd0 : 4'(wr_cnt_q + 4'd1);
    end
    // Fill and drain never target the same buffer in one cycle
    if (complete) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (drain) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
`ifdef AES_SR_BIDIR_EN
      mode_q   <= 2'b11;
`endif
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
      if (accept) begin
        buf_q[wr_sel_q][{wr_cnt_q, 3'b000} +: 8] <= bus.in_data;
      end
`ifdef AES_SR_BIDIR_EN
      if (accept && (wr_cnt_q == 4'd0)) begin
        mode_q[wr_sel_q] <= bus.mode;
      end
`endif
    end
  end

  always_comb begin
`ifdef AES_SR_BIDIR_EN
    bus.out_data = mode_q[rd_sel_q] ? inv_shift_rows(buf_q[rd_sel_q])
                                    : fwd_shift_rows(buf_q[rd_sel_q]);
`else
    bus.out_data = inv_shift_rows(buf_q[rd_sel_q]);
`endif
  end

endmodule

// File: tb/tb_aes_inv_shift_rows_stream.sv
// Directed bench for aes_inv_shift_rows_stream: instance A uses LAST_CHECK=1, instance B LAST_CHECK=0,
// both fed the same input stimulus.
module tb_aes_inv_shift_rows_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic mode = 1'b1;
  logic err_a, err_b;

  int asserts = 0;
  int fails = 0;
  int n_out_a = 0, n_out_b = 0, n_err_a = 0;

  localparam logic [127:0] E0 = 128'h0306090c0f0205080b0e0104070a0d00;
  localparam logic [127:0] B1 = 128'h1316191c1f1215181b1e1114171a1d10;
  localparam logic [127:0] B2 = 128'h2326292c2f2225282b2e2124272a2d20;
  localparam logic [127:0] B3 = 128'h3336393c3f3235383b3e3134373a3d30;
  localparam logic [127:0] B4 = 128'h4346494c4f4245484b4e4144474a4d40;
  localparam logic [127:0] B5 = 128'h5356595c5f5255585b5e5154575a5d50;
  localparam logic [127:0] B6 = 128'h6366696c6f6265686b6e6164676a6d60;
  localparam logic [127:0] B7 = 128'h7376797c7f7275787b7e7174777a7d70;

  always #5 clk = ~clk;

  aes_inv_shift_rows_stream_if ifa ();
  aes_inv_shift_rows_stream_if ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.in_last   = in_last;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.in_last   = in_last;
  assign ifb.out_ready = out_ready;
`ifdef AES_SR_BIDIR_EN
  assign ifa.mode = mode;
  assign ifb.mode = mode;
`endif

  aes_inv_shift_rows_stream #(.LAST_CHECK(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa), .err(err_a));
  aes_inv_shift_rows_stream #(.LAST_CHECK(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb), .err(err_b));

  always @(posedge clk) begin
    if (ifa.out_valid && ifa.out_ready) n_out_a <= n_out_a + 1;
    if (ifb.out_valid && ifb.out_ready) n_out_b <= n_out_b + 1;
    if (err_a) n_err_a <= n_err_a + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!ifa.in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!ifa.in_ready) begin
      asserts++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", ifa.in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] base, input logic with_last);
    for (int i = 0; i < 16; i++) send_byte(8'(base + 8'(i)), with_last && (i == 15));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    asserts++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", ifa.in_ready); end
    asserts++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid); end
    asserts++; if (ifa.out_data !== 128'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", ifa.out_data); end
    asserts++; if (err_a !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_a); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_block();
    int o0, e0;
    o0 = n_out_a; e0 = n_err_a;
    out_ready = 1'b1;
    send_block(8'h00, 1'b1);
    asserts++; if (ifa.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", ifa.out_valid); end
    asserts++; if (ifa.out_data !== E0) begin fails++; $display("FAIL single_data: got %h expected %h", ifa.out_data, E0); end
    tick();
    asserts++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL single_valid_1cyc: got %b expected 0", ifa.out_valid); end
    asserts++; if (n_out_a - o0 !== 1) begin fails++; $display("FAIL single_count: got %0d expected 1", n_out_a - o0); end
    asserts++; if (n_err_a - e0 !== 0) begin fails++; $display("FAIL single_err: got %0d expected 0", n_err_a - e0); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_block(8'h10, 1'b1);
    asserts++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after1: got %b expected 1", ifa.in_ready); end
    send_block(8'h20, 1'b1);
    asserts++; if (ifa.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_full: got %b expected 0", ifa.in_ready); end
    for (int k = 0; k < 3; k++) begin
      asserts++; if (ifa.out_data !== B1 || ifa.out_valid !== 1'b1 || ifa.in_ready !== 1'b0) begin
        fails++; $display("FAIL b2b_stall: data %h vld %b rdy %b expected %h 1 0", ifa.out_data, ifa.out_valid, ifa.in_ready, B1);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    asserts++; if (ifa.out_data !== B2 || ifa.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_second: data %h vld %b expected %h 1", ifa.out_data, ifa.out_valid, B2); end
    asserts++; if (ifa.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_freed: got %b expected 1", ifa.in_ready); end
    tick();
    asserts++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b expected 0", ifa.out_valid); end
    out_ready = 1'b0;
    send_block(8'h30, 1'b1);
    asserts++; if (ifa.out_data !== B3 || ifa.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_third: data %h vld %b expected %h 1", ifa.out_data, ifa.out_valid, B3); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_early_last();
    int o0, e0;
    out_ready = 1'b1;
    o0 = n_out_a; e0 = n_err_a;
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + 8'(i)), i == 5);
    asserts++; if (err_a !== 1'b1) begin fails++; $display("FAIL early_err_pulse: got %b expected 1", err_a); end
    asserts++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL early_no_out: got %b expected 0", ifa.out_valid); end
    send_block(8'h40, 1'b1);
    asserts++; if (ifa.out_data !== B4 || ifa.out_valid !== 1'b1) begin fails++; $display("FAIL early_clean: data %h vld %b expected %h 1", ifa.out_data, ifa.out_valid, B4); end
    tick();
    asserts++; if (n_out_a - o0 !== 1) begin fails++; $display("FAIL early_count: got %0d expected 1", n_out_a - o0); end
    asserts++; if (n_err_a - e0 !== 1) begin fails++; $display("FAIL early_err_count: got %0d expected 1", n_err_a - e0); end
  endtask

  task automatic test_missing_last();
    int oa, ob, e0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    out_ready = 1'b1;
    oa = n_out_a; ob = n_out_b; e0 = n_err_a;
    send_block(8'h50, 1'b0);
    asserts++; if (err_a !== 1'b1) begin fails++; $display("FAIL nolast_err: got %b expected 1", err_a); end
    asserts++; if (ifa.out_valid !== 1'b0) begin fails++; $display("FAIL nolast_no_out: got %b expected 0", ifa.out_valid); end
    asserts++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== B5) begin fails++; $display("FAIL nolast_count_only: data %h vld %b expected %h 1", ifb.out_data, ifb.out_valid, B5); end
    asserts++; if (err_b !== 1'b0) begin fails++; $display("FAIL nolast_err_b: got %b expected 0", err_b); end
    tick();
    asserts++; if (n_out_a - oa !== 0 || n_out_b - ob !== 1) begin fails++; $display("FAIL nolast_counts: a %0d b %0d expected 0 1", n_out_a - oa, n_out_b - ob); end
    asserts++; if (n_err_a - e0 !== 1) begin fails++; $display("FAIL nolast_err_count: got %0d expected 1", n_err_a - e0); end
  endtask

  task automatic test_reset_mid();
    int o0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(8'(8'h80 + 8'(i)), 1'b0);
    rst = 1'b1; #1;
    asserts++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.out_data !== 128'h0) begin
      fails++; $display("FAIL rst_partial: vld %b rdy %b data %h expected 0 1 0", ifa.out_valid, ifa.in_ready, ifa.out_data);
    end
    tick(); rst = 1'b0; tick();
    out_ready = 1'b0;
    send_block(8'h70, 1'b1);
    asserts++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== B7) begin fails++; $display("FAIL rst_realign: data %h vld %b expected %h 1", ifa.out_data, ifa.out_valid, B7); end
    o0 = n_out_a;
    rst = 1'b1; #1;
    asserts++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin fails++; $display("FAIL rst_pending: vld %b rdy %b expected 0 1", ifa.out_valid, ifa.in_ready); end
    tick(); rst = 1'b0; tick();
    out_ready = 1'b1;
    send_block(8'h60, 1'b1);
    asserts++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== B6) begin fails++; $display("FAIL rst_next_block: data %h vld %b expected %h 1", ifa.out_data, ifa.out_valid, B6); end
    tick();
    asserts++; if (n_out_a - o0 !== 1) begin fails++; $display("FAIL rst_discard_count: got %0d expected 1", n_out_a - o0); end
  endtask

`ifdef AES_SR_BIDIR_EN
  task automatic test_bidir();
    logic [127:0] fwd_exp, id_exp, res;
    fwd_exp = 128'h0b06010c07020d08030e09040f0a0500;
    id_exp  = 128'h0f0e0d0c0b0a09080706050403020100;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mode = (i == 0) ? 1'b0 : 1'b1;
      send_byte(8'(i), i == 15);
    end
    res = ifa.out_data;
    asserts++; if (res !== fwd_exp) begin fails++; $display("FAIL bidir_fwd: got %h expected %h", res, fwd_exp); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mode = (i == 0) ? 1'b1 : 1'b0;
      send_byte(res[8*i +: 8], i == 15);
    end
    asserts++; if (ifa.out_data !== id_exp) begin fails++; $display("FAIL bidir_roundtrip: got %h expected %h", ifa.out_data, id_exp); end
    out_ready = 1'b1; tick();
    mode = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_reset_mid();
`ifdef AES_SR_BIDIR_EN
    test_bidir();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
